// File: rtl/phase_counter_if.sv
// phase_counter_if
//   Bundles the control and status signals between the traffic controller
//   FSM (master) and the phase counter (slave).
//   Signals:
//     r        preset request (count <= LOAD_VAL)
//     ld       parallel load enable
//     ld_val   parallel load value, WIDTH bits
//     up, dn   up/down count enables (up wins when both are high)
//     count    registered phase value, WIDTH bits
//     wrap_up  one-cycle strobe on an up step from MODULUS-1 to 0
//     wrap_dn  one-cycle strobe on a down step from 0 to MODULUS-1
//     step     one-cycle strobe on any up/down count step
//   WIDTH must match the WIDTH parameter of the attached phase_counter.
interface phase_counter_if #(
  parameter int unsigned WIDTH = 2
);
  logic             r;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             up;
  logic             dn;
  logic [WIDTH-1:0] count;
  logic             wrap_up;
  logic             wrap_dn;
  logic             step;

  modport master (
    output r, ld, ld_val, up, dn,
    input  count, wrap_up, wrap_dn, step
  );

  modport slave (
    input  r, ld, ld_val, up, dn,
    output count, wrap_up, wrap_dn, step
  );
endinterface

// File: rtl/phase_counter.sv
// phase_counter
//   Modulo-MODULUS up/down phase counter with preset, clamped parallel load,
//   step prescaler and one-cycle wrap/step strobes. All outputs registered.
//   Ports:
//     clk    rising-edge clock
//     clr_n  synchronous active-low clear (highest priority)
//     bus    phase_counter_if.slave: r, ld, ld_val, up, dn in;
//            count, wrap_up, wrap_dn, step out
//   Parameters:
//     WIDTH     count width in bits
//     MODULUS   number of phases, 2 <= MODULUS <= 2**WIDTH
//     LOAD_VAL  preset value applied by r, < MODULUS
//     PRESCALE  enabled up/dn cycles per count step, >= 1
//   Build option:
//     PHASE_CNT_SAT_EN  when defined, count saturates at 0 and MODULUS-1
//                       instead of wrapping; wrap strobes stay 0 and step is
//                       0 on a blocked step.
module phase_counter #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MODULUS  = 3,
  parameter int unsigned LOAD_VAL = 2,
  parameter int unsigned PRESCALE = 1
) (
  input logic            clk,
  input logic            clr_n,
  phase_counter_if.slave bus
);

  localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WP1 = WIDTH + 1;

  // Bounds kept one bit wider than count so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W    = WP1'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W    = WP1'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LOAD_C   = WIDTH'(LOAD_VAL);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic             step_q, step_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ldv_ext;

  always_comb begin
    cnt_ext   = {1'b0, count_q};
    ldv_ext   = {1'b0, bus.ld_val};
    count_d   = count_q;
    pre_d     = pre_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    step_d    = 1'b0;

    if (bus.r) begin
      count_d = LOAD_C;
      pre_d   = '0;
    end else if (bus.ld) begin
      count_d = (ldv_ext < MOD_W) ? bus.ld_val : MAX_C;
      pre_d   = '0;
    end else if (bus.up || bus.dn) begin
      if (pre_q == PRE_LAST) begin
        // The prescaler rolls over even when a saturated step is blocked.
        pre_d = '0;
        if (bus.up) begin
          if (cnt_ext == MAX_W) begin
`ifdef PHASE_CNT_SAT_EN
            count_d = count_q;
`else
            count_d   = '0;
            wrap_up_d = 1'b1;
            step_d    = 1'b1;
`endif
          end else begin
            count_d = count_q + 1'b1;
            step_d  = 1'b1;
          end
        end else begin
          if (cnt_ext == '0) begin
`ifdef PHASE_CNT_SAT_EN
            count_d = count_q;
`else
            count_d   = MAX_C;
            wrap_dn_d = 1'b1;
            step_d    = 1'b1;
`endif
          end else begin
            count_d = count_q - 1'b1;
            step_d  = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q   <= '0;
      pre_q     <= '0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      pre_q     <= pre_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      step_q    <= step_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap_up = wrap_up_q;
  assign bus.wrap_dn = wrap_dn_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_phase_counter.sv
// tb_phase_counter
//   Four phase_counter instances:
//     u0  defaults (WIDTH=2, MODULUS=3, LOAD_VAL=2, PRESCALE=1)
//     u1  WIDTH=3, MODULUS=5, LOAD_VAL=0
//     u2  defaults with PRESCALE=3
//     u3  WIDTH=2, MODULUS=4 (full range), LOAD_VAL=1
//   Directed vectors push hand-computed expectations tagged with the cycle
//   they become visible; a negedge monitor pops and compares them.
//   Expectations follow PHASE_CNT_SAT_EN when it is defined.
module tb_phase_counter;

`ifdef PHASE_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       clr_n_t [4];
  logic       r_t     [4];
  logic       ld_t    [4];
  logic       up_t    [4];
  logic       dn_t    [4];
  logic [2:0] ldv_t   [4];

  phase_counter_if #(.WIDTH(2)) if0 ();
  phase_counter_if #(.WIDTH(3)) if1 ();
  phase_counter_if #(.WIDTH(2)) if2 ();
  phase_counter_if #(.WIDTH(2)) if3 ();

  assign if0.r = r_t[0];  assign if0.ld = ld_t[0];  assign if0.up = up_t[0];
  assign if0.dn = dn_t[0]; assign if0.ld_val = ldv_t[0][1:0];
  assign if1.r = r_t[1];  assign if1.ld = ld_t[1];  assign if1.up = up_t[1];
  assign if1.dn = dn_t[1]; assign if1.ld_val = ldv_t[1];
  assign if2.r = r_t[2];  assign if2.ld = ld_t[2];  assign if2.up = up_t[2];
  assign if2.dn = dn_t[2]; assign if2.ld_val = ldv_t[2][1:0];
  assign if3.r = r_t[3];  assign if3.ld = ld_t[3];  assign if3.up = up_t[3];
  assign if3.dn = dn_t[3]; assign if3.ld_val = ldv_t[3][1:0];

  phase_counter #(.WIDTH(2), .MODULUS(3), .LOAD_VAL(2), .PRESCALE(1))
    u0 (.clk(clk), .clr_n(clr_n_t[0]), .bus(if0));
  phase_counter #(.WIDTH(3), .MODULUS(5), .LOAD_VAL(0), .PRESCALE(1))
    u1 (.clk(clk), .clr_n(clr_n_t[1]), .bus(if1));
  phase_counter #(.WIDTH(2), .MODULUS(3), .LOAD_VAL(2), .PRESCALE(3))
    u2 (.clk(clk), .clr_n(clr_n_t[2]), .bus(if2));
  phase_counter #(.WIDTH(2), .MODULUS(4), .LOAD_VAL(1), .PRESCALE(1))
    u3 (.clk(clk), .clr_n(clr_n_t[3]), .bus(if3));

  // exp packs {count[2:0], wrap_up, wrap_dn, step}
  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    logic [5:0]  exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  function automatic logic [5:0] actual(input int unsigned d);
    case (d)
      0:       return {1'b0, if0.count, if0.wrap_up, if0.wrap_dn, if0.step};
      1:       return {if1.count, if1.wrap_up, if1.wrap_dn, if1.step};
      2:       return {1'b0, if2.count, if2.wrap_up, if2.wrap_dn, if2.step};
      default: return {1'b0, if3.count, if3.wrap_up, if3.wrap_dn, if3.step};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [5:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = actual(e.dut);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s u%0d: got count=%0d wrap_up=%b wrap_dn=%b step=%b, want count=%0d wrap_up=%b wrap_dn=%b step=%b",
                 e.name, e.dut, a[5:3], a[2], a[1], a[0],
                 e.exp[5:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  // One cycle: apply inputs to DUT d and queue the result expected after the next edge.
  task automatic drive(input int unsigned d, input logic c, input logic rr,
                       input logic l, input logic [2:0] lv, input logic u,
                       input logic dd, input logic [2:0] ec, input logic ewu,
                       input logic ewd, input logic est, input string nm);
    exp_t e;
    @(negedge clk);
    clr_n_t[d] = c;
    r_t[d]     = rr;
    ld_t[d]    = l;
    ldv_t[d]   = lv;
    up_t[d]    = u;
    dn_t[d]    = dd;
    e.cyc  = cyc + 1;
    e.dut  = d;
    e.exp  = {ec, ewu, ewd, est};
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      clr_n_t[i] = 1'b0; r_t[i] = 1'b0; ld_t[i] = 1'b0;
      ldv_t[i] = '0; up_t[i] = 1'b0; dn_t[i] = 1'b0;
    end

    // ---------------- u0: defaults ----------------
    //          d c r l lv u dn cnt wu wd st
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "u0_rst_a");
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "u0_rst_b_over_r_up");
`ifdef PHASE_CNT_SAT_EN
    drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u0_sat_up_0to1");
    drive(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1, "u0_sat_up_1to2");
    drive(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "u0_sat_up_hold_a");
    drive(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "u0_sat_up_hold_b");
    drive(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, "u0_sat_dn_2to1");
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "u0_sat_dn_1to0");
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "u0_sat_dn_hold");
`else
    drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u0_up_0to1");
    drive(0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1, "u0_up_1to2");
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, "u0_up_wrap");
    drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u0_up_0to1_again");
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "u0_dn_1to0");
    drive(0, 1, 0, 0, 0, 0, 1, 2, 0, 1, 1, "u0_dn_wrap");
    drive(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, "u0_dn_2to1");
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "u0_dn_1to0_again");
`endif
    drive(0, 1, 1, 0, 0, 1, 1, 2, 0, 0, 0, "u0_r_over_up_dn");
    drive(0, 1, 0, 0, 0, 1, 1, SAT ? 3'd2 : 3'd0, !SAT, 0, !SAT, "u0_up_wins_over_dn");
    drive(0, 1, 0, 1, 3, 1, 0, 2, 0, 0, 0, "u0_ld_clamp_3");
    drive(0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, "u0_ld_1_over_up");
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "u0_idle_hold");
    drive(0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, "u0_clr_over_all");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "u0_idle_after_clr");

    // ---------------- u1: WIDTH=3, MODULUS=5 ----------------
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "u1_rst");
    drive(1, 1, 0, 1, 7, 0, 0, 4, 0, 0, 0, "u1_ld_clamp_7");
    drive(1, 1, 0, 1, 5, 0, 0, 4, 0, 0, 0, "u1_ld_clamp_5");
    drive(1, 1, 0, 1, 3, 0, 0, 3, 0, 0, 0, "u1_ld_3");
    drive(1, 1, 0, 0, 0, 1, 0, 4, 0, 0, 1, "u1_up_3to4");
    drive(1, 1, 0, 0, 0, 1, 0, SAT ? 3'd4 : 3'd0, !SAT, 0, !SAT, "u1_up_at_max");
    drive(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, "u1_r_load0");
    drive(1, 1, 0, 0, 0, 0, 1, SAT ? 3'd0 : 3'd4, 0, !SAT, !SAT, "u1_dn_at_zero");
    drive(1, 1, 0, 0, 0, 0, 0, SAT ? 3'd0 : 3'd4, 0, 0, 0, "u1_idle");

    // ---------------- u2: PRESCALE=3 ----------------
    drive(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "u2_rst");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_up_c1");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_up_c2");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u2_up_c3_step");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "u2_up_c4");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "u2_up_c5");
    drive(2, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1, "u2_up_c6_step");
    drive(2, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "u2_up_pre1");
    drive(2, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "u2_up_pre2");
    drive(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_clr_mid_prescale");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_post_clr_c1");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_post_clr_c2");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u2_post_clr_c3_step");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "u2_hold_c1");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "u2_hold_c2");
    drive(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "u2_idle_keeps_pre");
    drive(2, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1, "u2_hold_c3_step");
    drive(2, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, "u2_pre_before_ld");
    drive(2, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, "u2_ld0_clears_pre");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_post_ld_c1");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_post_ld_c2");
    drive(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, "u2_post_ld_c3_step");
    drive(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "u2_dn_c1");
    drive(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "u2_dn_c2");
    drive(2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "u2_dn_c3_step");
    drive(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "u2_pre_before_r");
    drive(2, 1, 1, 0, 0, 1, 0, 2, 0, 0, 0, "u2_r_clears_pre");
    drive(2, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, "u2_post_r_c1");
    drive(2, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, "u2_post_r_c2");
    drive(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, "u2_post_r_c3_step");
    drive(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "u2_idle");

    // ---------------- u3: MODULUS = 2**WIDTH ----------------
    drive(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "u3_rst");
    drive(3, 1, 0, 0, 0, 0, 1, SAT ? 3'd0 : 3'd3, 0, !SAT, !SAT, "u3_dn_at_zero");
    drive(3, 1, 0, 0, 0, 1, 0, SAT ? 3'd1 : 3'd0, !SAT, 0, 1, "u3_up_from_dn_result");
    drive(3, 1, 0, 1, 3, 0, 0, 3, 0, 0, 0, "u3_ld_max_no_clamp");
    drive(3, 1, 0, 0, 0, 1, 0, SAT ? 3'd3 : 3'd0, !SAT, 0, !SAT, "u3_up_at_full_max");
    drive(3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "u3_r_load1");
    drive(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "u3_idle");

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 8 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d expectations still pending, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_counter.md
Name: phase_counter

Overview:
- Parametrised modulo-N up/down phase counter for the traffic-signal controller.
- Generalises the fixed 2-bit phase counter in four ways: configurable width and modulus, symmetric wrap in both directions, arbitrary parallel load, and a step prescaler.
- Emits one-cycle wrap strobes so the downstream light sequencer can detect cycle completion.
- Sits between the controller FSM (drives r/ld/up/dn) and the lamp decoder (consumes count).

Parameters:
- WIDTH, 2, count width in bits.
- MODULUS, 3, number of phases; count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH.
- LOAD_VAL, 2, preset value applied by r. Must be < MODULUS.
- PRESCALE, 1, number of enabled cycles per count step. Must be >= 1; 1 means step every enabled cycle.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  synchronous active-low clear.
- r  in  1  preset: count <= LOAD_VAL.
- ld  in  1  parallel load enable.
- ld_val  in  WIDTH  parallel load value.
- up  in  1  active-high up-count enable.
- dn  in  1  active-high down-count enable.
- count  out  WIDTH  registered phase value.
- wrap_up  out  1  one-cycle strobe: up step from MODULUS-1 to 0.
- wrap_dn  out  1  one-cycle strobe: down step from 0 to MODULUS-1.
- step  out  1  one-cycle strobe: count changed due to up/dn on this edge.

Behaviour:
- All state changes on posedge clk. All outputs are registered.
- Reset: clr_n low at an edge gives count=0, wrap_up=0, wrap_dn=0, step=0, internal prescaler=0.
  - Reset has priority over every other input.
  - Reset mid-prescale discards the partial prescale count.
- Priority, highest first: clr_n low > r > ld > up > dn. If up and dn are both high, up wins and dn is ignored.
- r: count <= LOAD_VAL; prescaler <= 0; all strobes 0.
- ld: count <= ld_val if ld_val < MODULUS, else count <= MODULUS-1 (clamp). Prescaler <= 0; strobes 0.
- Prescaler (pre_cnt, width = clog2 of PRESCALE, minimum 1 bit):
  - Advances only in cycles where up or dn is the winning action.
  - When pre_cnt == PRESCALE-1, a step occurs and pre_cnt <= 0; otherwise pre_cnt increments and count holds.
  - Holds its value when no action is asserted.
- Up step: count <= (count == MODULUS-1) ? 0 : count+1. wrap_up=1 only on the wrap.
- Down step: count <= (count == 0) ? MODULUS-1 : count-1. wrap_dn=1 only on the wrap.
- step=1 on every up/down step edge, including wraps. Strobes are 0 in all non-step cycles.
- Latency: one cycle from qualifying input to count and strobe update.
- count never leaves 0..MODULUS-1 after reset.
- Arithmetic is done in WIDTH+1 bits internally, so the MODULUS = 2**WIDTH case does not overflow.
- No action asserted: count and pre_cnt hold; strobes 0.

Optional Feature:
- Macro: PHASE_CNT_SAT_EN.
- Defined: saturating mode.
  - Up at MODULUS-1 holds count.
  - Dn at 0 holds count.
  - wrap_up and wrap_dn are tied to 0.
  - step is 0 on a blocked step.
  - Prescaler still resets to 0 on the blocked step edge.
- Undefined: wrapping behaviour as specified above.
- r, ld and reset behave identically in both builds.

Test Plan:
- Defaults (WIDTH=2, MODULUS=3, PRESCALE=1): clr_n=0 for 2 cycles, then up=1 for 4 cycles -> count 0,1,2,0,1; wrap_up=1 only on the 2->0 edge; step=1 on every edge.
- Defaults: from count=0, dn=1 for 3 cycles -> count 2,1,0; wrap_dn=1 on the 0->2 edge only; count never reaches 3.
- Defaults: r=1 with up=1 and dn=1 -> count=2, step=0. Then up=1 and dn=1 -> count=0 with wrap_up=1 (up wins).
- WIDTH=3, MODULUS=5: ld=1, ld_val=7 -> count=4 (clamp). Then ld_val=3 -> count=3. Then up for 2 cycles -> 4, 0 with wrap_up=1.
- PRESCALE=3: up held for 6 cycles from 0 -> count changes only on cycles 3 and 6 (0->1->2), step pulses twice. Reassert clr_n=0 after 2 up cycles -> count=0 and the next step needs 3 full up cycles.
- PHASE_CNT_SAT_EN defined, defaults: up for 4 cycles from 0 -> 1, 2, 2, 2 with wrap_up=0 throughout. Then dn for 3 cycles -> 1, 0, 0 with wrap_dn=0.
